// File: rtl/dec38_step.sv
// Sequential 3-to-8 decoder with seven-segment readout and prescaled auto-step.
// Define DEC38_STEP_BOUNCE_EN for ping-pong stepping in RUN instead of modulo-8 wrap.
module dec38_step #(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       en,
  input  logic       load,
  input  logic [2:0] code_in,
  input  logic       run,
  input  logic       dir,
  output logic [7:0] onehot,
  output logic [6:0] hex_code,
  output logic [6:0] hex_act,
  output logic       wrap,
  output logic [2:0] code
);

  localparam logic [25:0] TickMax = 26'(TICK_DIV - 1);

  typedef enum logic [1:0] {StIdle, StHold, StRun} state_e;

  state_e      state_q, state_d;
  logic [2:0]  code_q, code_d;
  logic [25:0] presc_q, presc_d;
  logic        wrap_q, wrap_d;
  logic        tick;
  logic        step_up;

`ifdef DEC38_STEP_BOUNCE_EN
  logic bdir_q, bdir_d;
`endif

  function automatic logic [6:0] seg7(input logic [2:0] v);
    logic [6:0] s;
    unique case (v)
      3'd0:    s = 7'b1000000;
      3'd1:    s = 7'b1111001;
      3'd2:    s = 7'b0100100;
      3'd3:    s = 7'b0110000;
      3'd4:    s = 7'b0011001;
      3'd5:    s = 7'b0010010;
      3'd6:    s = 7'b0000010;
      default: s = 7'b1111000;
    endcase
    return s;
  endfunction

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    presc_d = '0;
    wrap_d  = 1'b0;
    tick    = 1'b0;
`ifdef DEC38_STEP_BOUNCE_EN
    bdir_d  = bdir_q;
`endif

    if (en) begin
      state_d = run ? StRun : StHold;
      if (load) begin
        code_d = code_in;
      end else if (state_q == StRun && run) begin
        // Stays in RUN: advance prescaler; a tick returns it to zero.
        if (presc_q == TickMax) tick = 1'b1;
        else                    presc_d = presc_q + 26'd1;
      end
    end else begin
      state_d = StIdle;
    end

`ifdef DEC38_STEP_BOUNCE_EN
    if (state_q != StRun && state_d == StRun) bdir_d = dir;
    step_up = bdir_q;
`else
    step_up = dir;
`endif

    if (tick) begin
`ifdef DEC38_STEP_BOUNCE_EN
      if (step_up) begin
        if (code_q == 3'd7) begin
          code_d = 3'd6;
          bdir_d = 1'b0;
          wrap_d = 1'b1;
        end else begin
          code_d = code_q + 3'd1;
        end
      end else begin
        if (code_q == 3'd0) begin
          code_d = 3'd1;
          bdir_d = 1'b1;
          wrap_d = 1'b1;
        end else begin
          code_d = code_q - 3'd1;
        end
      end
`else
      if (step_up) begin
        code_d = code_q + 3'd1;
        wrap_d = (code_q == 3'd7);
      end else begin
        code_d = code_q - 3'd1;
        wrap_d = (code_q == 3'd0);
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= StIdle;
      code_q  <= '0;
      presc_q <= '0;
      wrap_q  <= 1'b0;
`ifdef DEC38_STEP_BOUNCE_EN
      bdir_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      presc_q <= presc_d;
      wrap_q  <= wrap_d;
`ifdef DEC38_STEP_BOUNCE_EN
      bdir_q  <= bdir_d;
`endif
    end
  end

  always_comb begin
    if (state_q == StIdle) begin
      onehot   = '0;
      hex_code = 7'b1111111;
      hex_act  = 7'b1000000;
    end else begin
      onehot   = 8'b1 << code_q;
      hex_code = seg7(code_q);
      hex_act  = 7'b1111001;
    end
    wrap = wrap_q;
    code = code_q;
  end

endmodule

// File: tb/tb_dec38_step.sv
// Self-checking bench for dec38_step: directed scenarios then random traffic against
// a behavioural model of the decoder's per-edge rules.
module tb_dec38_step;

  localparam int unsigned TickDiv = 4;

  logic       clk = 1'b0;
  logic       clrn, en, load, run, dir;
  logic [2:0] code_in;
  logic [7:0] onehot;
  logic [6:0] hex_code, hex_act;
  logic       wrap;
  logic [2:0] code;

  dec38_step #(.TICK_DIV(TickDiv)) dut (
    .clk      (clk),
    .clrn     (clrn),
    .en       (en),
    .load     (load),
    .code_in  (code_in),
    .run      (run),
    .dir      (dir),
    .onehot   (onehot),
    .hex_code (hex_code),
    .hex_act  (hex_act),
    .wrap     (wrap),
    .code     (code)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Model: 0 = idle, 1 = hold, 2 = run
  int m_st, m_code, m_cnt, m_wrap, m_bd;
  logic [6:0] seg_tab [8] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000};

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_code = 0; m_cnt = 0; m_wrap = 0; m_bd = 0;
  endtask

  task automatic model_edge();
    int prev, nxt;
    bit do_tick, up;
    if (!clrn) begin
      model_reset();
      return;
    end
    m_wrap  = 0;
    do_tick = 0;
    if (!en) begin
      m_st  = 0;
      m_cnt = 0;
      return;
    end
    prev = m_st;
    nxt  = run ? 2 : 1;
    if (prev != 2 && nxt == 2) m_bd = dir;
    if (load) begin
      m_code = code_in;
      m_cnt  = 0;
    end else if (prev == 2 && nxt == 2) begin
      if (m_cnt == TickDiv - 1) begin
        m_cnt   = 0;
        do_tick = 1;
      end else begin
        m_cnt++;
      end
    end else begin
      m_cnt = 0;
    end
    if (do_tick) begin
`ifdef DEC38_STEP_BOUNCE_EN
      up = m_bd[0];
      if (up && m_code == 7) begin
        m_code = 6; m_bd = 0; m_wrap = 1;
      end else if (!up && m_code == 0) begin
        m_code = 1; m_bd = 1; m_wrap = 1;
      end else begin
        m_code = up ? m_code + 1 : m_code - 1;
      end
`else
      up = dir;
      if (up) begin
        m_wrap = (m_code == 7);
        m_code = (m_code + 1) % 8;
      end else begin
        m_wrap = (m_code == 0);
        m_code = (m_code + 7) % 8;
      end
`endif
    end
    m_st = nxt;
  endtask

  task automatic check_model(input string tag);
    logic [7:0] e_oh;
    logic [6:0] e_hc, e_ha;
    if (m_st == 0) begin
      e_oh = 8'h00; e_hc = 7'b1111111; e_ha = 7'b1000000;
    end else begin
      e_oh = 8'(1) << m_code; e_hc = seg_tab[m_code]; e_ha = 7'b1111001;
    end
    check({tag, ".onehot"},   onehot,          e_oh);
    check({tag, ".hex_code"}, {1'b0, hex_code}, {1'b0, e_hc});
    check({tag, ".hex_act"},  {1'b0, hex_act},  {1'b0, e_ha});
    check({tag, ".wrap"},     {7'b0, wrap},     8'(m_wrap));
    check({tag, ".code"},     {5'b0, code},     8'(m_code));
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_model(tag);
  endtask

  initial begin
    logic [2:0] saved;

    // Reset with random inputs, checked asynchronously before any edge
    clrn = 1'b0; en = 1'($urandom); load = 1'($urandom); run = 1'($urandom);
    dir = 1'($urandom); code_in = 3'($urandom);
    #3;
    model_reset();
    check_model("reset_async");
    repeat (3) begin
      en = 1'($urandom); load = 1'($urandom); run = 1'($urandom);
      dir = 1'($urandom); code_in = 3'($urandom);
      cycle("reset_hold");
    end
    clrn = 1'b1; en = 1'b0; load = 1'b1; run = 1'b1;
    repeat (2) cycle("release_en0");
    check("release_onehot", onehot, 8'h00);

    // Load 5
    en = 1'b1; load = 1'b1; run = 1'b0; code_in = 3'd5;
    cycle("load5");
    check("load5_onehot", onehot, 8'h20);
    check("load5_hex", {1'b0, hex_code}, 8'b0010010);
    check("load5_act", {1'b0, hex_act}, 8'b1111001);
    load = 1'b0;
    cycle("hold5");

    // Auto-step up from 6
    load = 1'b1; code_in = 3'd6;
    cycle("load6");
    load = 1'b0; run = 1'b1; dir = 1'b1;
    cycle("run_entry_up");
    repeat (TickDiv) cycle("step_up1");
    check("up_first", {5'b0, code}, 8'd7);
    repeat (TickDiv - 1) cycle("step_up2");
    check("up_no_wrap_yet", {7'b0, wrap}, 8'd0);
    cycle("step_up_wrap");
`ifdef DEC38_STEP_BOUNCE_EN
    check("up_turn_code", {5'b0, code}, 8'd6);
`else
    check("up_wrap_code", {5'b0, code}, 8'd0);
    check("up_wrap_onehot", onehot, 8'h01);
`endif
    check("up_wrap_pulse", {7'b0, wrap}, 8'd1);
    cycle("after_wrap");
    check("wrap_one_cycle", {7'b0, wrap}, 8'd0);

    // Down from 1, then drop run on a tick edge
    run = 1'b0;
    cycle("stop");
    load = 1'b1; code_in = 3'd1;
    cycle("load1");
    load = 1'b0; run = 1'b1; dir = 1'b0;
    cycle("run_entry_down");
    repeat (TickDiv) cycle("step_dn1");
    check("down_first", {5'b0, code}, 8'd0);
    repeat (TickDiv) cycle("step_dn2");
    check("down_wrap_pulse", {7'b0, wrap}, 8'd1);
    repeat (TickDiv - 1) cycle("pre_drop");
    saved = code;
    run = 1'b0;
    cycle("drop_on_tick");
    check("drop_no_step", {5'b0, code}, {5'b0, saved});
    cycle("hold_after_drop");

    // Disable mid-RUN, then re-enable
    run = 1'b1;
    repeat (2) cycle("run_again");
    en = 1'b0;
    cycle("disable");
    check("disable_onehot", onehot, 8'h00);
    cycle("disabled");
    en = 1'b1;
    cycle("reenable");
    repeat (TickDiv + 2) cycle("reenable_run");

    // Asynchronous reset mid-RUN
    @(posedge clk); model_edge(); #2;
    clrn = 1'b0;
    #1;
    model_reset();
    check_model("async_reset");
    cycle("in_reset");
    clrn = 1'b1;
    cycle("post_reset");

    // Random traffic
    repeat (400) begin
      clrn    = ($urandom_range(0, 99) != 0);
      en      = ($urandom_range(0, 9) != 0);
      load    = ($urandom_range(0, 7) == 0);
      run     = ($urandom_range(0, 5) != 0);
      dir     = (m_st == 2) ? ($urandom_range(0, 9) != 0 ? dir : ~dir) : 1'($urandom);
      code_in = 3'($urandom);
      cycle("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dec38_step.md
# dec38_step

Sequential 3-to-8 decoder with a seven-segment readout: the output-side counterpart of the 8-to-3 priority encoder experiment. Holds a 3-bit code, drives a one-hot 8-bit LED vector and active-low seven-segment digits for the code and an "active" flag. An auto-step mode walks the lit LED through positions 0..7 at a prescaled rate. This block is the LED/display front end for board experiments.

## Interface
- `TICK_DIV`, default 50_000_000: clock cycles per auto-step; legal range 2..2^26.
- `clk`  in  1  system clock, rising edge.
- `clrn`  in  1  asynchronous active-low reset.
- `en`  in  1  decoder enable; low forces IDLE.
- `load`  in  1  when high on an edge with `en`=1, `code_in` is captured.
- `code_in`  in  3  code to load.
- `run`  in  1  auto-step request.
- `dir`  in  1  step direction: 1 = up (+1), 0 = down (−1).
- `onehot`  out  8  `onehot[code]`=1 when active; 0 in IDLE.
- `hex_code`  out  7  active-low gfedcba digit of `code`; 1111111 (blank) in IDLE.
- `hex_act`  out  7  1111001 ("1") when active; 1000000 ("0") in IDLE.
- `wrap`  out  1  one-cycle pulse on wrap/turnaround in RUN.
- `code`  out  3  current code register.

## Operation
- Digit patterns: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000.
- States:
  - IDLE: reached on reset or whenever `en`=0.
  - HOLD: displays `code`; no stepping.
  - RUN: steps on each tick.
- Transitions, evaluated every edge, priority top-down:
  - `en`=0 → IDLE. `load` and `run` ignored; `code` retained.
  - IDLE with `en`=1 → HOLD, or RUN if `run`=1.
  - HOLD with `run`=1 → RUN.
  - RUN with `run`=0 → HOLD.
- Load: `en`=1 and `load`=1 sets `code`←`code_in` in any non-disabled state, including the edge leaving IDLE. Load also clears the prescaler. The state transition still applies on that edge.
- Prescaler: 26-bit counter, cleared on entry to RUN, on load, and in IDLE/HOLD. In RUN it counts 0..TICK_DIV−1. A tick occurs when it equals TICK_DIV−1; the counter then returns to 0. A load edge suppresses the step.
- Step on tick: `code`←`code`±1 mod 8 per `dir`, sampled at the tick edge. Wrap (7→0 up, 0→7 down) asserts `wrap` for exactly one cycle.
- `run` dropping on the same edge as a tick: the step does not occur; the block goes to HOLD.

## Timing
- Reset values: state IDLE, `code`=000, prescaler 0, `onehot`=00000000, `hex_code`=1111111, `hex_act`=1000000, `wrap`=0.
- All outputs are combinational decodes of registered state. They are glitch-free relative to `clk` and change one edge after the causing input is sampled.
- Load latency: 1 cycle. The first auto-step occurs TICK_DIV edges after RUN entry or after a load.
- `wrap` is registered and aligned with the `code` update.
- Reset asserted mid-RUN returns everything to reset values immediately, asynchronously. Release takes effect on the next edge.

## Configuration
- `DEC38_STEP_BOUNCE_EN` defined: ping-pong stepping in RUN.
  - An internal direction bit is loaded from `dir` on RUN entry.
  - At 7 going up the next code is 6; at 0 going down the next code is 1. The direction bit flips at each end and `wrap` pulses on every turnaround.
  - `dir` is ignored while in RUN.
- Undefined: modulo-8 wrap as above. `dir` is sampled live at every tick.

## Test plan
All scenarios use TICK_DIV=4.
- Reset: `clrn`=0 with random inputs → `onehot`=00, `hex_code`=1111111, `hex_act`=1000000, `wrap`=0. Release with `en`=0 → unchanged.
- Load: `en`=1, `load`=1, `code_in`=5 for one edge → next cycle `onehot`=0x20, `hex_code`=0010010, `hex_act`=1111001, state HOLD.
- Auto-step up: from `code`=6, `run`=1, `dir`=1 → `code`=7 after 4 edges, then 0 after 8 edges with `wrap`=1 for that single cycle, `onehot`=0x01, `hex_code`=1000000.
- Down and stop: `code`=1, `dir`=0, `run`=1 → 0, then 7 with `wrap`. Drop `run` on a tick edge → no step, HOLD.
- Disable mid-RUN: `en`=0 → next cycle all outputs show IDLE values and `code` is retained. Re-enable → original digit shown; in RUN, first step occurs 4 edges later.
- With `DEC38_STEP_BOUNCE_EN`: from 6 going up → sequence 7, 6, …, 0, 1. `wrap` pulses at 7 and at 0.
